uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   UART transmitter, the outgoing counterpart of the MAIN block's rx path.
//   Serialises one parallel byte per valid/ready handshake into an 8N1 frame on tx,
//   or a parameterised variant (start, LSB-first data, optional parity, 1-2 stops).
//   Bit timing comes from a fixed clocks-per-bit divider on the single system clock.
//   Default timing matches the bench rate: 10 clk per bit.
// PARAMETERS
//   CLKS_PER_BIT  10  clk cycles per serial bit; legal range >= 2
//   DATA_BITS      8  data bits per frame; legal range 5..8
//   PARITY         0  0 = none, 1 = odd, 2 = even
//   STOP_BITS      1  stop bits per frame; legal range 1..2
// PORTS
//   clk       in   1          system clock, rising edge
//   rst       in   1          asynchronous reset, active-low (0 = reset)
//   tx_data   in   DATA_BITS  byte to send; sampled only on the handshake
//   tx_valid  in   1          source has data on tx_data
//   tx_ready  out  1          transmitter idle and able to accept
//   tx        out  1          serial line; idle level 1
//   busy      out  1          frame in progress (= !tx_ready)
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; tx=1, tx_ready=1, busy=0; counters and
//     shift register cleared.
//   Reset mid-frame: tx returns to 1 immediately and the frame is abandoned.
//     No partial frame resumes after release.
//   FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE: tx=1, tx_ready=1.
//     On a rising edge with tx_valid & tx_ready: latch tx_data into the shift
//     register, clear bit counter, go to START.
//     tx_valid while not in IDLE is ignored; no queueing.
//     Changes on tx_data after acceptance do not affect the frame in flight.
//   START: tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after acceptance.
//   DATA: DATA_BITS bits, each held CLKS_PER_BIT cycles, LSB first.
//     Shift right at each bit boundary.
//   PARITY (skipped when PARITY=0): one bit period carrying the parity bit.
//     Odd: tx = ~^data. Even: tx = ^data. Computed over the latched data.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//   Bit timer: counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT). Wraps at
//     CLKS_PER_BIT-1 and advances the bit or state. No drift across a frame.
//   Frame length: L = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles
//     of non-idle output.
//   Back-to-back traffic (tx_valid held high): exactly one IDLE cycle (tx=1,
//     tx_ready=1) between frames. Throughput is one byte per L+1 cycles.
//   tx is driven from a register: glitch-free and changes only on clk edges.
//   tx_ready and busy are registered state decodes, valid from the same edge as tx.
// TESTING
//   1. Reset: hold rst=0 with clk running, then release -> tx=1, tx_ready=1, busy=0.
//      tx stays 1 with tx_valid=0 for 100 cycles.
//   2. Single 8N1 byte 0x47, defaults: one-cycle tx_valid pulse -> tx_ready low next
//      cycle; tx = 0,1,1,1,0,0,0,1,0,1, each held exactly 10 cycles (100 cycles
//      total); tx_ready returns 1. Check by looping back into MAIN rx.
//   3. Back-to-back 0x47 then 0xA5 with tx_valid held: exactly 2 handshakes;
//      one idle cycle between frames; second frame bits LSB-first 1,0,1,0,0,1,0,1.
//   4. Parity/stop: PARITY=2, STOP_BITS=2, data 0x07 -> parity bit 1 and 20 stop
//      cycles. Same data with PARITY=1 -> parity bit 0.
//   5. Ignore and hold: pulse tx_valid with 0xFF and change tx_data mid-frame while
//      sending 0x00 -> line carries 0x00 unchanged; no second frame starts.
//   6. Reset mid-frame: assert rst=0 during the 4th data bit -> tx=1 in the same
//      cycle, asynchronously. After release, tx_ready=1 and a new 0x47 frame is
//      bit-exact.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Latency: line drops to the start bit on the edge that accepts the byte.
// Backpressure: tx_ready is high only in IDLE; tx_valid elsewhere is ignored.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,  // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,       // asynchronous, active-low
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;     // data index in DATA, stop index in STOP
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tick;

  // Bit boundary: the timer has spent CLKS_PER_BIT cycles on the current bit.
  assign tick = (cnt_q == CNT_LAST);

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next state; tx_d is the level of the bit being entered so tx stays registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
          bit_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        tx_d  = 1'b1;
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

endmodule
